// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types, constants and opcode helpers for the RV32M
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    // Constants are held at the widest supported datapath and sliced per instance
    localparam int          MULDIV_MAX_WIDTH = 64;
    localparam logic [63:0] DIV0_QUOTIENT    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MOST_NEGATIVE    = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module      : muldiv_step
//  Description : One radix-2 iteration: shift-add multiply or restoring
//                subtract-shift divide on unsigned magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_mode,
    input  logic [2*DATA_WIDTH-1:0]   i_acc,
    input  logic [DATA_WIDTH-1:0]     i_operand,
    output logic [2*DATA_WIDTH-1:0]   o_acc,
    output logic                      o_quot_bit
);

    logic [DATA_WIDTH:0] w_mul_sum;
    logic [DATA_WIDTH:0] w_rem_shift;
    logic [DATA_WIDTH:0] w_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        w_mul_sum   = {1'b0, i_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (i_acc[0] ? {1'b0, i_operand} : {(DATA_WIDTH+1){1'b0}});
        w_rem_shift = i_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
        w_diff      = w_rem_shift - {1'b0, i_operand};
        o_quot_bit  = 1'b0;
        o_acc       = '0;
        if (i_mode) begin
            o_quot_bit = ~w_diff[DATA_WIDTH];
            o_acc      = {(o_quot_bit ? w_diff[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0]),
                          i_acc[DATA_WIDTH-2:0], 1'b0};
        end else begin
            o_acc      = {w_mul_sum, i_acc[DATA_WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit with valid/ready on both
//                sides. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     busy
);

    localparam int                          c_cnt_w        = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0]          c_cnt_init     = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0]       c_div0_q       = DIV0_QUOTIENT[DATA_WIDTH-1:0];
    localparam logic [MULDIV_MAX_WIDTH-1:0] c_most_neg_all = MOST_NEGATIVE >> (MULDIV_MAX_WIDTH - DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]       c_most_neg     = c_most_neg_all[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0]       c_minus_one    = '1;

    muldiv_state_t             r_state, w_state_next;
    muldiv_op_t                r_op, w_op;
    logic [c_cnt_w-1:0]        r_count;
    logic [2*DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]     r_operand;
    logic [DATA_WIDTH-1:0]     r_result;
    logic                      r_is_div;
    logic                      r_neg_result;
    logic                      r_neg_rem;

    logic                      w_sign_a, w_sign_b, w_is_rem, w_div0, w_ovf, w_fast;
    logic [DATA_WIDTH-1:0]     w_mag_a, w_mag_b, w_fast_result, w_final_result;
    logic [DATA_WIDTH-1:0]     w_quot_mag, w_rem_mag;
    logic [2*DATA_WIDTH-1:0]   w_step_acc, w_acc_next, w_prod;
    logic                      w_step_qbit;

    assign w_op     = muldiv_op_t'(Operation[2:0]);
    assign w_sign_a = is_signed_a(w_op) & SrcA[DATA_WIDTH-1];
    assign w_sign_b = is_signed_b(w_op) & SrcB[DATA_WIDTH-1];
    assign w_mag_a  = w_sign_a ? (~SrcA + 1'b1) : SrcA;
    assign w_mag_b  = w_sign_b ? (~SrcB + 1'b1) : SrcB;
    assign w_is_rem = w_op inside {OP_REM, OP_REMU};
    assign w_div0   = is_div(w_op) && (SrcB == '0);
    assign w_ovf    = is_div(w_op) && is_signed_a(w_op) && (SrcA == c_most_neg) && (SrcB == c_minus_one);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0]   w_ext_a, w_ext_b, w_fast_prod;
    assign w_ext_a     = {{DATA_WIDTH{w_sign_a}}, SrcA};
    assign w_ext_b     = {{DATA_WIDTH{w_sign_b}}, SrcB};
    // Low 2W bits of the sign-extended product equal the true signed product
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = '0;
        if (w_div0) begin
            w_fast        = 1'b1;
            w_fast_result = w_is_rem ? SrcA : c_div0_q;
        end else if (w_ovf) begin
            w_fast        = 1'b1;
            w_fast_result = w_is_rem ? '0 : c_most_neg;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div(w_op)) begin
            w_fast        = 1'b1;
            w_fast_result = (w_op == OP_MUL) ? w_fast_prod[DATA_WIDTH-1:0]
                                             : w_fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end
`endif
    end

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_mode     (r_is_div),
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .o_acc      (w_step_acc),
        .o_quot_bit (w_step_qbit)
    );

    assign w_acc_next = {w_step_acc[2*DATA_WIDTH-1:1], r_is_div ? w_step_qbit : w_step_acc[0]};

    // Sign fix-up applied to the value the final iteration produces
    always_comb begin
        w_prod     = r_neg_result ? (~w_acc_next + 1'b1) : w_acc_next;
        w_quot_mag = w_acc_next[DATA_WIDTH-1:0];
        w_rem_mag  = w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
        case (r_op)
            OP_MUL:                      w_final_result = w_prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:             w_final_result = r_neg_result ? (~w_quot_mag + 1'b1) : w_quot_mag;
            default:                     w_final_result = r_neg_rem ? (~w_rem_mag + 1'b1) : w_rem_mag;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_MUL;
            r_count      <= '0;
            r_acc        <= '0;
            r_operand    <= '0;
            r_result     <= '0;
            r_is_div     <= 1'b0;
            r_neg_result <= 1'b0;
            r_neg_rem    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op         <= w_op;
                        r_is_div     <= is_div(w_op);
                        r_neg_result <= w_sign_a ^ w_sign_b;
                        r_neg_rem    <= w_sign_a;
                        r_count      <= c_cnt_init;
                        // Divide iterates the dividend through acc; multiply iterates the multiplier
                        if (is_div(w_op)) begin
                            r_acc     <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                            r_operand <= w_mag_b;
                        end else begin
                            r_acc     <= {{DATA_WIDTH{1'b0}}, w_mag_b};
                            r_operand <= w_mag_a;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_result;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_result <= w_final_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit against an arithmetic
//                reference model; honours MULDIV_FAST_MUL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] SrcA = '0;
    logic [DW-1:0] SrcB = '0;
    logic [2:0]    Operation = '0;
    logic          in_ready, out_valid, busy;
    logic [DW-1:0] Result;

    int n_vectors     = 0;
    int n_miscompares = 0;

    muldiv_unit #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      ub = {32'b0, b};
        logic [63:0] ua = {32'b0, a};
        logic [63:0] uu = {32'b0, b};
        logic [63:0] p;
        case (op)
            3'd0: begin p = sa * sb;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * uu;  return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, wait for the result, hold it for 'hold' cycles, then retire it.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold);
        int   lat;
        int   exp_lat;
        logic ready_seen;
        logic fast;
        fast = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) fast = 1'b1;
`endif
        exp_lat = fast ? 1 : DW + 1;
        check($sformatf("op%0d idle in_ready", op), in_ready, 1);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        Operation  = 3'($urandom);
        lat        = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat <= DW + 5) begin
            ready_seen |= in_ready;
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check($sformatf("op%0d latency", op), lat, exp_lat);
        check($sformatf("op%0d in_ready while busy", op), ready_seen, 0);
        check($sformatf("op%0d busy in done", op), busy, 1);
        check($sformatf("op%0d result a=%h b=%h", op, a, b), Result, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            SrcA     = $urandom;
            SrcB     = $urandom;
            @(posedge clk); #1;
            check($sformatf("op%0d stall out_valid", op), out_valid, 1);
            check($sformatf("op%0d stall result", op), Result, exp);
            check($sformatf("op%0d stall in_ready", op), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("op%0d retired out_valid", op), out_valid, 0);
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset Result", Result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op(d_op[i], d_a[i], d_b[i], d_exp[i], (i == 1) ? 10 : 0);
        end

        // Abort a divide part-way through its iterations
        in_valid  = 1'b1;
        Operation = 3'd4;
        SrcA      = 32'd100;
        SrcB      = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort Result", Result, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(3'd4, 32'd9, 32'd3, 32'd3, 0);

        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, ref_muldiv(op, a, b), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
